// File: rtl/k423_pcu_pkg.sv
// Shared types and helpers for the k423 scoreboarded pipeline control unit.
// onehot_idx is sized for PCU_RIDX_W; the PCU's RIDX_W parameter must not exceed it.
package k423_pcu_pkg;

   localparam int PCU_RIDX_W  = 5;
   localparam int PCU_REG_NUM = 2 ** PCU_RIDX_W;
   localparam int PCU_CNT_W   = 3;
   localparam int PCU_PERF_W  = 32;

   typedef enum logic [0:0] {
      PCU_IDLE  = 1'b0,
      PCU_FLUSH = 1'b1
   } pcu_state_e;

   // Register index to one-hot mask; x0 is hardwired zero and never tracked.
   function automatic logic [PCU_REG_NUM-1:0] onehot_idx(input logic [PCU_RIDX_W-1:0] idx);
      logic [PCU_REG_NUM-1:0] mask;
      mask      = '0;
      mask[idx] = 1'b1;
      mask[0]   = 1'b0;
      return mask;
   endfunction

endpackage

// File: rtl/k423_pcu_scoreboard.sv
// Per-register pending table for variable-latency producers, with same-cycle
// issue visibility and same-cycle writeback release toward the ID stage.
module k423_pcu_scoreboard
   import k423_pcu_pkg::*;
#(
   parameter int RIDX_W = PCU_RIDX_W
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              issue_vld_i,
   input  logic [RIDX_W-1:0] issue_idx_i,
   input  logic              done_vld_i,
   input  logic [RIDX_W-1:0] done_idx_i,
   input  logic              rs1_vld_i,
   input  logic [RIDX_W-1:0] rs1_idx_i,
   input  logic              rs2_vld_i,
   input  logic [RIDX_W-1:0] rs2_idx_i,
   output logic              haz_o,
   output logic              busy_o
);

   localparam int REG_NUM = 2 ** RIDX_W;

   logic [PCU_REG_NUM-1:0] issue_oh;
   logic [PCU_REG_NUM-1:0] done_oh;
   logic [REG_NUM-1:0]     issue_mask;
   logic [REG_NUM-1:0]     done_mask;
   logic [REG_NUM-1:0]     sb_q;
   logic [REG_NUM-1:0]     sb_d;
   logic [REG_NUM-1:0]     sb_eff;

   assign issue_oh   = onehot_idx(PCU_RIDX_W'(issue_idx_i));
   assign done_oh    = onehot_idx(PCU_RIDX_W'(done_idx_i));
   assign issue_mask = issue_vld_i ? issue_oh[REG_NUM-1:0] : '0;
   assign done_mask  = done_vld_i  ? done_oh[REG_NUM-1:0]  : '0;

   // Stored state lets a same-index issue win; the ID view lets writeback win (forwarded).
   assign sb_d   = (sb_q & ~done_mask) | issue_mask;
   assign sb_eff = (sb_q | issue_mask) & ~done_mask;

   assign haz_o = (rs1_vld_i & sb_eff[rs1_idx_i] & (rs1_idx_i != '0))
                | (rs2_vld_i & sb_eff[rs2_idx_i] & (rs2_idx_i != '0));

   assign busy_o = |sb_q;

   // NOTE: the table is a plain flop vector, not a RAM, so it is reset: a stale bit would stall ID forever.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         sb_q <= '0;
      end else begin
         sb_q <= sb_d;
      end
   end

endmodule

// File: rtl/k423_pcu_sb.sv
// Scoreboarded pipeline control unit: hazard/full stall and programmable flush window.
// Define K423_PCU_PERF_EN to build the saturating stall-cycle and flush-event counters.
module k423_pcu_sb
   import k423_pcu_pkg::*;
#(
   parameter int RIDX_W    = PCU_RIDX_W,
   parameter int MAX_OUTST = 4,
   parameter int FLUSH_CYC = 1
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic                  id_dec_rs1_vld_i,
   input  logic [RIDX_W-1:0]     id_dec_rs1_idx_i,
   input  logic                  id_dec_rs2_vld_i,
   input  logic [RIDX_W-1:0]     id_dec_rs2_idx_i,
   input  logic                  id_dec_long_i,
   input  logic                  ex_issue_vld_i,
   input  logic                  ex_rd_vld_i,
   input  logic [RIDX_W-1:0]     ex_rd_idx_i,
   input  logic                  ex_rd_long_i,
   input  logic                  wb_done_vld_i,
   input  logic [RIDX_W-1:0]     wb_done_idx_i,
   input  logic                  wb_bju_br_tkn_i,
   output logic                  pcu_stall_o,
   output logic                  pcu_flush_o,
   output logic                  pcu_sb_busy_o,
   output logic [PCU_PERF_W-1:0] pcu_perf_stall_o,
   output logic [PCU_PERF_W-1:0] pcu_perf_flush_o
);

   localparam int                   OUT_W      = 4;
   localparam logic [OUT_W:0]       OUT_MAX    = (OUT_W + 1)'(MAX_OUTST);
   localparam logic [PCU_CNT_W-1:0] CNT_RELOAD = PCU_CNT_W'(FLUSH_CYC - 1);
   localparam bit                   MULTI_CYC  = (FLUSH_CYC > 1);

   pcu_state_e           state_q, state_d;
   logic [PCU_CNT_W-1:0] cnt_q, cnt_d;
   logic [OUT_W-1:0]     outst_q, outst_d;
   logic [OUT_W:0]       outst_nxt;
   logic                 flush;
   logic                 long_issue;
   logic                 sb_issue;
   logic                 haz;
   logic                 full;
   logic                 stall;

   assign flush      = wb_bju_br_tkn_i | (state_q == PCU_FLUSH);
   assign long_issue = ex_issue_vld_i & ex_rd_long_i & ~flush;
   assign sb_issue   = long_issue & ex_rd_vld_i;

   // Same-cycle occupancy: what the slots hold once this cycle's issue and writeback land.
   assign outst_nxt = {1'b0, outst_q} + {{OUT_W{1'b0}}, long_issue} - {{OUT_W{1'b0}}, wb_done_vld_i};
   assign outst_d   = outst_nxt[OUT_W-1:0];
   assign full      = id_dec_long_i & (outst_nxt >= OUT_MAX);
   assign stall     = (haz | full) & ~flush;

   k423_pcu_scoreboard #(
      .RIDX_W (RIDX_W)
   ) u_scoreboard (
      .clk_i       (clk_i),
      .rst_n_i     (rst_n_i),
      .issue_vld_i (sb_issue),
      .issue_idx_i (ex_rd_idx_i),
      .done_vld_i  (wb_done_vld_i),
      .done_idx_i  (wb_done_idx_i),
      .rs1_vld_i   (id_dec_rs1_vld_i),
      .rs1_idx_i   (id_dec_rs1_idx_i),
      .rs2_vld_i   (id_dec_rs2_vld_i),
      .rs2_idx_i   (id_dec_rs2_idx_i),
      .haz_o       (haz),
      .busy_o      (pcu_sb_busy_o)
   );

   // NOTE: every always_comb target gets a default first, so no path leaves a latch behind.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         PCU_IDLE: begin
            if (wb_bju_br_tkn_i && MULTI_CYC) begin
               state_d = PCU_FLUSH;
               cnt_d   = CNT_RELOAD;
            end
         end
         PCU_FLUSH: begin
            if (wb_bju_br_tkn_i) begin
               cnt_d = CNT_RELOAD;
            end else if (cnt_q == PCU_CNT_W'(1)) begin
               state_d = PCU_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - PCU_CNT_W'(1);
            end
         end
         default: begin
            state_d = PCU_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q <= PCU_IDLE;
         cnt_q   <= '0;
         outst_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         outst_q <= outst_d;
      end
   end

   assign pcu_stall_o = stall;
   assign pcu_flush_o = flush;

`ifdef K423_PCU_PERF_EN
   logic [PCU_PERF_W-1:0] perf_stall_q;
   logic [PCU_PERF_W-1:0] perf_flush_q;

   // Every taken branch is a new flush event: an IDLE entry or a FLUSH-window reload.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         perf_stall_q <= '0;
         perf_flush_q <= '0;
      end else begin
         if (stall && (perf_stall_q != '1)) perf_stall_q <= perf_stall_q + 1'b1;
         if (wb_bju_br_tkn_i && (perf_flush_q != '1)) perf_flush_q <= perf_flush_q + 1'b1;
      end
   end

   assign pcu_perf_stall_o = perf_stall_q;
   assign pcu_perf_flush_o = perf_flush_q;
`else
   assign pcu_perf_stall_o = '0;
   assign pcu_perf_flush_o = '0;
`endif

   a_outst_underflow: assert property (@(posedge clk_i) disable iff (!rst_n_i)
      !(wb_done_vld_i && !long_issue && (outst_q == '0)));

   a_outst_overflow: assert property (@(posedge clk_i) disable iff (!rst_n_i)
      !(long_issue && !wb_done_vld_i && (outst_q >= OUT_W'(MAX_OUTST))));

endmodule

// File: tb/tb_k423_pcu_sb.sv
// Directed bench for k423_pcu_sb built with MAX_OUTST=2 and FLUSH_CYC=3.
// Perf counter expectations follow K423_PCU_PERF_EN (zero when undefined).
module tb_k423_pcu_sb;

   logic        clk_i = 1'b0;
   logic        rst_n_i;
   logic        id_dec_rs1_vld_i;
   logic [4:0]  id_dec_rs1_idx_i;
   logic        id_dec_rs2_vld_i;
   logic [4:0]  id_dec_rs2_idx_i;
   logic        id_dec_long_i;
   logic        ex_issue_vld_i;
   logic        ex_rd_vld_i;
   logic [4:0]  ex_rd_idx_i;
   logic        ex_rd_long_i;
   logic        wb_done_vld_i;
   logic [4:0]  wb_done_idx_i;
   logic        wb_bju_br_tkn_i;
   logic        pcu_stall_o;
   logic        pcu_flush_o;
   logic        pcu_sb_busy_o;
   logic [31:0] pcu_perf_stall_o;
   logic [31:0] pcu_perf_flush_o;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk_i = ~clk_i;

   k423_pcu_sb #(
      .RIDX_W    (5),
      .MAX_OUTST (2),
      .FLUSH_CYC (3)
   ) dut (
      .clk_i            (clk_i),
      .rst_n_i          (rst_n_i),
      .id_dec_rs1_vld_i (id_dec_rs1_vld_i),
      .id_dec_rs1_idx_i (id_dec_rs1_idx_i),
      .id_dec_rs2_vld_i (id_dec_rs2_vld_i),
      .id_dec_rs2_idx_i (id_dec_rs2_idx_i),
      .id_dec_long_i    (id_dec_long_i),
      .ex_issue_vld_i   (ex_issue_vld_i),
      .ex_rd_vld_i      (ex_rd_vld_i),
      .ex_rd_idx_i      (ex_rd_idx_i),
      .ex_rd_long_i     (ex_rd_long_i),
      .wb_done_vld_i    (wb_done_vld_i),
      .wb_done_idx_i    (wb_done_idx_i),
      .wb_bju_br_tkn_i  (wb_bju_br_tkn_i),
      .pcu_stall_o      (pcu_stall_o),
      .pcu_flush_o      (pcu_flush_o),
      .pcu_sb_busy_o    (pcu_sb_busy_o),
      .pcu_perf_stall_o (pcu_perf_stall_o),
      .pcu_perf_flush_o (pcu_perf_flush_o)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic clr();
      id_dec_rs1_vld_i = 1'b0;
      id_dec_rs1_idx_i = '0;
      id_dec_rs2_vld_i = 1'b0;
      id_dec_rs2_idx_i = '0;
      id_dec_long_i    = 1'b0;
      ex_issue_vld_i   = 1'b0;
      ex_rd_vld_i      = 1'b0;
      ex_rd_idx_i      = '0;
      ex_rd_long_i     = 1'b0;
      wb_done_vld_i    = 1'b0;
      wb_done_idx_i    = '0;
      wb_bju_br_tkn_i  = 1'b0;
   endtask

   // Start of a new cycle: 1 time unit after the rising edge, inputs back to idle.
   task automatic tick();
      @(posedge clk_i);
      #1;
      clr();
   endtask

   task automatic issue(input logic [4:0] rd);
      ex_issue_vld_i = 1'b1;
      ex_rd_vld_i    = 1'b1;
      ex_rd_idx_i    = rd;
      ex_rd_long_i   = 1'b1;
   endtask

   task automatic done(input logic [4:0] rd);
      wb_done_vld_i = 1'b1;
      wb_done_idx_i = rd;
   endtask

   task automatic rs1(input logic [4:0] idx);
      id_dec_rs1_vld_i = 1'b1;
      id_dec_rs1_idx_i = idx;
   endtask

   task automatic rs2(input logic [4:0] idx);
      id_dec_rs2_vld_i = 1'b1;
      id_dec_rs2_idx_i = idx;
   endtask

   task automatic check_perf(input string tag, input int exp_stall, input int exp_flush);
`ifdef K423_PCU_PERF_EN
      check({tag, "_perf_stall"}, pcu_perf_stall_o, 32'(exp_stall));
      check({tag, "_perf_flush"}, pcu_perf_flush_o, 32'(exp_flush));
`else
      check({tag, "_perf_stall"}, pcu_perf_stall_o, 32'(exp_stall * 0));
      check({tag, "_perf_flush"}, pcu_perf_flush_o, 32'(exp_flush * 0));
`endif
   endtask

   initial begin
      clr();
      rst_n_i = 1'b0;
      repeat (2) tick();
      #1;
      check("rst_busy",  32'(pcu_sb_busy_o), 0);
      check("rst_stall", 32'(pcu_stall_o),   0);
      check("rst_flush", 32'(pcu_flush_o),   0);
      check_perf("rst", 0, 0);
      rst_n_i = 1'b1;

      // Load rd=5, consumer rs1=5 waits until writeback.
      tick(); issue(5);          #1; check("t1_c0_stall", 32'(pcu_stall_o), 0);
      tick(); rs1(5);            #1; check("t1_c1_stall", 32'(pcu_stall_o), 1);
                                     check("t1_c1_busy",  32'(pcu_sb_busy_o), 1);
      tick(); rs1(5);            #1; check("t1_c2_stall", 32'(pcu_stall_o), 1);
      tick(); rs1(5);            #1; check("t1_c3_stall", 32'(pcu_stall_o), 1);
      tick(); rs1(5); done(5);   #1; check("t1_c4_stall", 32'(pcu_stall_o), 0);
                                     check("t1_c4_busy",  32'(pcu_sb_busy_o), 1);
      tick(); rs1(5);            #1; check("t1_c5_stall", 32'(pcu_stall_o), 0);
                                     check("t1_c5_busy",  32'(pcu_sb_busy_o), 0);
      check_perf("t1", 3, 0);

      // Same-cycle issue visible to ID; same-index done+issue keeps the bit.
      tick(); issue(7); rs2(7);  #1; check("t2_same_issue_stall", 32'(pcu_stall_o), 1);
      tick(); done(7); issue(7); #1; check("t2_done_issue_stall", 32'(pcu_stall_o), 0);
      tick(); rs2(7);            #1; check("t2_bit7_busy",  32'(pcu_sb_busy_o), 1);
                                     check("t2_bit7_stall", 32'(pcu_stall_o), 1);
      tick(); done(7);           #1; check("t2_release_stall", 32'(pcu_stall_o), 0);
      tick();                    #1; check("t2_idle_busy", 32'(pcu_sb_busy_o), 0);

      // rd=0 long ops: no bit, but they occupy slots (MAX_OUTST=2).
      tick(); rs1(0); issue(0);  #1; check("t3_x0_stall", 32'(pcu_stall_o), 0);
      tick(); rs1(0); issue(0); id_dec_long_i = 1'b1;
                                 #1; check("t3_x0_busy",  32'(pcu_sb_busy_o), 0);
                                     check("t3_full_issue_stall", 32'(pcu_stall_o), 1);
      tick(); id_dec_long_i = 1'b1; #1; check("t3_full_stall", 32'(pcu_stall_o), 1);
      tick(); id_dec_long_i = 1'b1; done(0); #1; check("t3_first_done_stall", 32'(pcu_stall_o), 0);
      tick(); id_dec_long_i = 1'b1; done(0); #1; check("t3_second_done_stall", 32'(pcu_stall_o), 0);
      tick(); id_dec_long_i = 1'b1; #1; check("t3_empty_stall", 32'(pcu_stall_o), 0);

      // Slots full with real rds; unrelated ID read still stalls on full.
      tick(); issue(3);          #1; check("t4_issue3_stall", 32'(pcu_stall_o), 0);
      tick(); issue(4); rs1(9); id_dec_long_i = 1'b1;
                                 #1; check("t4_full_a", 32'(pcu_stall_o), 1);
      tick(); rs1(9); id_dec_long_i = 1'b1; #1; check("t4_full_b", 32'(pcu_stall_o), 1);
      tick(); rs1(9); id_dec_long_i = 1'b1; done(4);
                                 #1; check("t4_done_release", 32'(pcu_stall_o), 0);

      // Flush window of 3 with rs1=3 hazard held; flush dominates stall.
      tick(); rs1(3);            #1; check("t5_pre_stall", 32'(pcu_stall_o), 1);
                                     check("t5_pre_flush", 32'(pcu_flush_o), 0);
      tick(); rs1(3); wb_bju_br_tkn_i = 1'b1; #1;
      check("t5_w0_flush", 32'(pcu_flush_o), 1); check("t5_w0_stall", 32'(pcu_stall_o), 0);
      tick(); rs1(3);            #1;
      check("t5_w1_flush", 32'(pcu_flush_o), 1); check("t5_w1_stall", 32'(pcu_stall_o), 0);
      tick(); rs1(3);            #1;
      check("t5_w2_flush", 32'(pcu_flush_o), 1); check("t5_w2_stall", 32'(pcu_stall_o), 0);
      tick(); rs1(3);            #1;
      check("t5_w3_flush", 32'(pcu_flush_o), 0); check("t5_w3_stall", 32'(pcu_stall_o), 1);

      // Second branch one cycle in reloads the window: flush over four cycles.
      tick(); rs1(3); wb_bju_br_tkn_i = 1'b1; #1;
      check("t5_r10_flush", 32'(pcu_flush_o), 1); check("t5_r10_stall", 32'(pcu_stall_o), 0);
      tick(); rs1(3); wb_bju_br_tkn_i = 1'b1; #1;
      check("t5_r11_flush", 32'(pcu_flush_o), 1); check("t5_r11_stall", 32'(pcu_stall_o), 0);
      tick(); rs1(3);            #1;
      check("t5_r12_flush", 32'(pcu_flush_o), 1); check("t5_r12_stall", 32'(pcu_stall_o), 0);
      tick(); rs1(3);            #1;
      check("t5_r13_flush", 32'(pcu_flush_o), 1); check("t5_r13_stall", 32'(pcu_stall_o), 0);
      tick(); rs1(3);            #1;
      check("t5_r14_flush", 32'(pcu_flush_o), 0); check("t5_r14_stall", 32'(pcu_stall_o), 1);
      check_perf("t5", 11, 3);

      // Three pending bits (3,4,6), then a mid-operation reset.
      tick(); rs1(3); issue(4);  #1; check("t6_a_stall", 32'(pcu_stall_o), 1);
      tick(); rs1(3); done(0);   #1; check("t6_b_stall", 32'(pcu_stall_o), 1);
      tick(); rs1(3); issue(6);  #1; check("t6_c_stall", 32'(pcu_stall_o), 1);
      tick(); rs1(3); rs2(6); rst_n_i = 1'b0;
                                 #1; check("t6_pre_rst_busy", 32'(pcu_sb_busy_o), 1);
                                     check("t6_pre_rst_stall", 32'(pcu_stall_o), 1);
      check_perf("t6_pre_rst", 15, 3);
      tick(); rs1(3); rs2(6);    #1;
      check("t6_rst_busy",  32'(pcu_sb_busy_o), 0);
      check("t6_rst_stall", 32'(pcu_stall_o),   0);
      check("t6_rst_flush", 32'(pcu_flush_o),   0);
      check_perf("t6_rst", 0, 0);
      rst_n_i = 1'b1;
      tick(); rs1(4);            #1; check("t6_post_stall", 32'(pcu_stall_o), 0);
                                     check("t6_post_busy",  32'(pcu_sb_busy_o), 0);

      tick();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
